voq_out_rr_scheduler: RTL and testbench
=======================================

# voq_out_rr_scheduler

Per-output-port packet scheduler for the shared-memory switch. Each input port's VOQ raises a request when it holds a packet for this output. The block arbitrates among those requests round-robin, one whole packet at a time. It then sequences word reads from the granted VOQ, using the head-packet length, until the packet is drained. One instance sits on each output port, between the input-side VOQ read logic and the output transmit path.

## Interface
Parameters:
- PORT_NUB, 4: number of input ports/requesters (≥2, need not be a power of two)
- WIDTH_LENGTH, 8: width of a packet length field, in words
- WIDTH_SEL, $clog2(PORT_NUB): width of the input-select index

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- req_in  input  PORT_NUB  bit i high means VOQ i holds ≥1 complete packet for this output
- length_in  input  PORT_NUB*WIDTH_LENGTH  packed head-packet lengths in words; slice i = bits [i*WIDTH_LENGTH +: WIDTH_LENGTH]
- ready_in  input  1  downstream accepts one word this cycle
- rd_en_out  output  PORT_NUB  one-hot read strobe to the granted VOQ, one word per strobe
- sel_out  output  WIDTH_SEL  index of the granted input; valid while busy_out
- busy_out  output  1  a packet transfer is in progress
- sop_out  output  1  qualifies the strobe carrying the first word
- eop_out  output  1  qualifies the strobe carrying the last word

## Operation
- State machine states:
  - IDLE: no grant; busy_out=0.
  - XFER: granted; busy_out=1.
- Round-robin pointer ptr (WIDTH_SEL bits).
  - The search starts at ptr and ascends modulo PORT_NUB.
  - The first set req_in bit wins.
  - After each grant, ptr = winner+1; if winner = PORT_NUB-1, ptr = 0.
- IDLE, any req_in set:
  - Register sel_out = winner.
  - Load remaining = length_in[winner] − 1; a length of 0 is treated as 1, so remaining = 0.
  - Set the first flag. Go to XFER.
- XFER:
  - rd_en_out[sel_out] = ready_in (combinational from registered state and ready_in). All other bits are 0.
  - sop_out = rd_en strobe & first. The first flag clears on the strobe.
  - eop_out = rd_en strobe & (remaining==0).
  - On a strobe with remaining≠0: decrement remaining.
  - On a strobe with remaining==0: packet done. Go to IDLE. busy_out clears next cycle.
- ready_in low: no strobe; remaining, first and sel_out hold.
- req_in and length_in are sampled only at grant. A request dropping or a length changing mid-packet is ignored.
- Requests from other inputs during XFER are not granted until the packet completes. Transfers are never preempted.
- Single-word packet: sop_out and eop_out assert on the same strobe.

## Timing
- Reset values:
  - rd_en_out=0, sel_out=0, busy_out=0, sop_out=0, eop_out=0
  - ptr=0, remaining=0, state IDLE
- Reset mid-packet: the transfer aborts immediately and asynchronously. No further strobes. The state after release is identical to power-up.
- Grant latency: req_in sampled high in IDLE at edge N gives busy_out=1 after edge N. The first possible strobe is in cycle N+1.
- A packet of L words with ready_in held high occupies L XFER cycles plus 1 IDLE arbitration cycle (without back-to-back).
- At most one rd_en_out bit is high in any cycle. No rd_en_out bit is high while busy_out=0.

## Configuration
- SCHED_BACK2BACK_EN defined:
  - On the eop strobe, arbitration runs in the same cycle against the current req_in, excluding the finishing input's req bit, using the updated ptr.
  - If a request is found, reload sel_out, remaining and first, and stay in XFER. There is no IDLE bubble.
  - If no request is found, go to IDLE.
- Not defined: always return to IDLE after eop. One bubble cycle per packet.

## Test plan
- req_in=0001, length_in[0]=3, ready_in=1 → busy_out high; rd_en_out=0001 for 3 consecutive cycles; sop on the 1st strobe, eop on the 3rd; ptr=1 afterwards.
- req_in=1011 held, all lengths=2, ready_in=1 → grant order 0,1,3,0,1,3; each packet exactly 2 strobes; never two rd_en bits high at once.
- Grant input 2 with length 4; toggle ready_in 1,0,0,1,1,0,1 → exactly 4 strobes, only on ready cycles; eop on the 4th; sel_out stays 2 throughout.
- length_in[1]=0, req_in=0010 → a single strobe with sop and eop both high; returns to IDLE.
- Assert rst after 2 of 5 words of a packet → all outputs 0 immediately; after release with req_in=0100, input 2 is granted (ptr was reset to 0).
- With SCHED_BACK2BACK_EN, req_in=0011, lengths 1 and 2 → strobes to input 0 then input 1 in consecutive cycles, no idle gap; busy_out stays high for 3 cycles. Without the macro: one idle cycle between the two packets.

Source files
------------

// File: rtl/voq_out_rr_scheduler_if.sv
// ---------------------------------------------------------------------------
// voq_out_rr_scheduler_if
// Bundles the request/length/ready inputs and the read-strobe outputs of one
// output-port scheduler.
//   req_in     : per-input "VOQ holds a complete packet for this output"
//   length_in  : packed head-packet lengths, slice i = [i*WIDTH_LENGTH +: WIDTH_LENGTH]
//   ready_in   : downstream accepts one word this cycle
//   rd_en_out  : one-hot read strobe to the granted VOQ
//   sel_out    : index of the granted input (meaningful while busy_out)
//   busy_out   : packet transfer in progress
//   sop_out    : strobe carries the first word of the packet
//   eop_out    : strobe carries the last word of the packet
// Modports: master = VOQ/transmit side, slave = scheduler.
// ---------------------------------------------------------------------------
interface voq_out_rr_scheduler_if #(
    parameter int PORT_NUB     = 4,
    parameter int WIDTH_LENGTH = 8,
    parameter int WIDTH_SEL    = $clog2(PORT_NUB)
);
    logic [PORT_NUB-1:0]              req_in;
    logic [PORT_NUB*WIDTH_LENGTH-1:0] length_in;
    logic                             ready_in;
    logic [PORT_NUB-1:0]              rd_en_out;
    logic [WIDTH_SEL-1:0]             sel_out;
    logic                             busy_out;
    logic                             sop_out;
    logic                             eop_out;

    modport master (
        output req_in, length_in, ready_in,
        input  rd_en_out, sel_out, busy_out, sop_out, eop_out
    );

    modport slave (
        input  req_in, length_in, ready_in,
        output rd_en_out, sel_out, busy_out, sop_out, eop_out
    );
endinterface

// File: rtl/voq_out_rr_scheduler.sv
// ---------------------------------------------------------------------------
// voq_out_rr_scheduler
// Per-output-port packet scheduler. Grants one requesting VOQ at a time in
// round-robin order and then issues one read strobe per ready cycle until the
// head packet (length taken at grant time) is drained.
// Ports:
//   clk   : system clock, rising edge
//   rst   : asynchronous active-high reset
//   i_bus : voq_out_rr_scheduler_if.slave (requests, lengths, ready in;
//           rd_en/sel/busy/sop/eop out)
// Optional feature: define SCHED_BACK2BACK_EN to re-arbitrate on the eop
// strobe and start the next packet without an IDLE bubble cycle.
// ---------------------------------------------------------------------------
module voq_out_rr_scheduler #(
    parameter int PORT_NUB     = 4,
    parameter int WIDTH_LENGTH = 8,
    parameter int WIDTH_SEL    = $clog2(PORT_NUB)
) (
    input  logic                      clk,
    input  logic                      rst,
    voq_out_rr_scheduler_if.slave     i_bus
);

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    localparam logic [WIDTH_SEL-1:0] LAST_PORT = WIDTH_SEL'(PORT_NUB - 1);

    state_t                  r_state;
    logic [WIDTH_SEL-1:0]    r_ptr;
    logic [WIDTH_SEL-1:0]    r_sel;
    logic [WIDTH_LENGTH-1:0] r_remaining;
    logic                    r_first;

    logic [PORT_NUB-1:0]     w_reqMask;
    logic                    w_found;
    logic [WIDTH_SEL-1:0]    w_winner;
    logic [WIDTH_LENGTH-1:0] w_headLen;
    logic [WIDTH_LENGTH-1:0] w_loadRem;
    logic [WIDTH_SEL-1:0]    w_nextPtr;
    logic                    w_strobe;
    logic                    w_lastWord;
    logic [PORT_NUB-1:0]     w_rdEn;

    // Round-robin search starting at r_ptr. While a packet is in flight the
    // current owner is masked out, so the back-to-back re-arbitration on the
    // eop strobe never re-grants the input that just finished. r_ptr already
    // points one past the current owner, which is the "updated" pointer.
    always_comb begin
        int idx;
        idx       = 0;
        w_found   = 1'b0;
        w_winner  = '0;
        w_reqMask = i_bus.req_in;
        if (r_state == XFER) begin
            w_reqMask[r_sel] = 1'b0;
        end
        for (int k = 0; k < PORT_NUB; k++) begin
            idx = int'(r_ptr) + k;
            if (idx >= PORT_NUB) begin
                idx = idx - PORT_NUB;
            end
            if (!w_found && w_reqMask[idx]) begin
                w_found  = 1'b1;
                w_winner = WIDTH_SEL'(idx);
            end
        end
    end

    // A zero-length head packet is still moved as a single word.
    assign w_headLen = i_bus.length_in[int'(w_winner)*WIDTH_LENGTH +: WIDTH_LENGTH];
    assign w_loadRem = (w_headLen == '0) ? '0 : w_headLen - WIDTH_LENGTH'(1);
    assign w_nextPtr = (w_winner == LAST_PORT) ? '0 : w_winner + WIDTH_SEL'(1);

    assign w_strobe   = (r_state == XFER) && i_bus.ready_in;
    assign w_lastWord = (r_remaining == '0);

    // Read strobe is combinational from registered state and ready so that the
    // VOQ sees it in the same cycle downstream accepts the word.
    always_comb begin
        w_rdEn = '0;
        if (w_strobe) begin
            w_rdEn[r_sel] = 1'b1;
        end
    end

    assign i_bus.rd_en_out = w_rdEn;
    assign i_bus.sel_out   = r_sel;
    assign i_bus.busy_out  = (r_state == XFER);
    assign i_bus.sop_out   = w_strobe && r_first;
    assign i_bus.eop_out   = w_strobe && w_lastWord;

    // Grant/transfer state machine. Requests and lengths only matter at the
    // moment of a grant; a stall (ready low) holds everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_sel       <= '0;
            r_remaining <= '0;
            r_first     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_sel       <= w_winner;
                        r_remaining <= w_loadRem;
                        r_first     <= 1'b1;
                        r_ptr       <= w_nextPtr;
                        r_state     <= XFER;
                    end
                end
                XFER: begin
                    if (w_strobe) begin
                        r_first <= 1'b0;
                        if (!w_lastWord) begin
                            r_remaining <= r_remaining - WIDTH_LENGTH'(1);
                        end else begin
`ifdef SCHED_BACK2BACK_EN
                            if (w_found) begin
                                r_sel       <= w_winner;
                                r_remaining <= w_loadRem;
                                r_first     <= 1'b1;
                                r_ptr       <= w_nextPtr;
                            end else begin
                                r_state <= IDLE;
                            end
`else
                            r_state <= IDLE;
`endif
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_voq_out_rr_scheduler.sv
// ---------------------------------------------------------------------------
// tb_voq_out_rr_scheduler
// Directed scenarios followed by randomized requests/lengths/ready. A
// transaction-level model decides which packet (input, word count) should be
// granted and pushes it into a scoreboard queue; a monitor on the falling
// edge checks every strobe against the head of that queue and pops it once
// the expected number of words has been seen.
// ---------------------------------------------------------------------------
module tb_voq_out_rr_scheduler;

    localparam int PN = 4;
    localparam int WL = 8;
    localparam int WS = 2;

    typedef struct {
        int port;
        int len;
    } pkt_t;

    logic clk = 1'b0;
    logic rst;

    int   checks      = 0;
    int   failures    = 0;
    int   packetsDone = 0;

    pkt_t expQ[$];
    bit   mBusy  = 1'b0;
    int   mPtr   = 0;
    int   mLeft  = 0;
    int   mPort  = 0;
    int   wordCount = 0;

    voq_out_rr_scheduler_if #(.PORT_NUB(PN), .WIDTH_LENGTH(WL), .WIDTH_SEL(WS)) bus ();

    voq_out_rr_scheduler #(.PORT_NUB(PN), .WIDTH_LENGTH(WL), .WIDTH_SEL(WS)) dut (
        .clk   (clk),
        .rst   (rst),
        .i_bus (bus)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic logic [PN*WL-1:0] packLens(input int l0, input int l1,
                                                  input int l2, input int l3);
        return {WL'(l3), WL'(l2), WL'(l1), WL'(l0)};
    endfunction

    // Round-robin pick: lowest index at or after mPtr (wrapping) whose request
    // is set, skipping 'exclude'. Records the expected packet on success.
    task automatic modelGrant(input int exclude, output bit found);
        int p;
        int len;
        found = 1'b0;
        for (int k = 0; k < PN; k++) begin
            p = (mPtr + k) % PN;
            if (!found && bus.req_in[p] && p != exclude) begin
                found = 1'b1;
                len   = int'(bus.length_in[p*WL +: WL]);
                if (len == 0) len = 1;
                expQ.push_back('{port: p, len: len});
                mPort = p;
                mLeft = len;
            end
        end
        if (found) mPtr = (mPort + 1) % PN;
    endtask

    // Reference model: one packet at a time, a word leaves on every ready
    // cycle while busy; after the last word either re-grant at once
    // (back-to-back build) or spend one idle cycle arbitrating.
    always @(posedge clk or posedge rst) begin
        bit g;
        if (rst) begin
            mBusy     = 1'b0;
            mPtr      = 0;
            mLeft     = 0;
            wordCount = 0;
            expQ.delete();
        end else if (mBusy) begin
            if (bus.ready_in) begin
                mLeft--;
                if (mLeft == 0) begin
`ifdef SCHED_BACK2BACK_EN
                    modelGrant(mPort, g);
                    mBusy = g;
`else
                    mBusy = 1'b0;
`endif
                end
            end
        end else begin
            modelGrant(-1, g);
            mBusy = g;
        end
    end

    // Monitor: compares busy every cycle and each strobe against the head
    // packet of the scoreboard (target, sop on first word, eop on last).
    always @(negedge clk) begin
        pkt_t p;
        if (!rst) begin
            checkOutput("busy_out", 32'(bus.busy_out), 32'(mBusy));
            if (mBusy && bus.ready_in) begin
                if (expQ.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL scoreboard_empty actual=strobe required=packet at %0t", $time);
                end else begin
                    p = expQ[0];
                    checkOutput("rd_en_out", 32'(bus.rd_en_out), 32'(1) << p.port);
                    checkOutput("sel_out", 32'(bus.sel_out), 32'(p.port));
                    checkOutput("sop_out", 32'(bus.sop_out), 32'(wordCount == 0));
                    checkOutput("eop_out", 32'(bus.eop_out), 32'(wordCount + 1 == p.len));
                    wordCount++;
                    if (wordCount == p.len) begin
                        void'(expQ.pop_front());
                        wordCount = 0;
                        packetsDone++;
                    end
                end
            end else begin
                checkOutput("rd_en_quiet", 32'(bus.rd_en_out), 32'(0));
                checkOutput("sop_quiet", 32'(bus.sop_out), 32'(0));
                checkOutput("eop_quiet", 32'(bus.eop_out), 32'(0));
            end
        end
    end

    // Drive inputs just after a rising edge and hold them for 'cycles' clocks.
    task automatic applyStimulus(input logic [PN-1:0] req, input logic [PN*WL-1:0] lens,
                                 input logic rdy, input int cycles);
        bus.req_in    = req;
        bus.length_in = lens;
        bus.ready_in  = rdy;
        repeat (cycles) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_rd_en"}, 32'(bus.rd_en_out), 32'(0));
        checkOutput({tag, "_sel"},   32'(bus.sel_out),   32'(0));
        checkOutput({tag, "_busy"},  32'(bus.busy_out),  32'(0));
        checkOutput({tag, "_sop"},   32'(bus.sop_out),   32'(0));
        checkOutput({tag, "_eop"},   32'(bus.eop_out),   32'(0));
    endtask

    // Stimulus sequence
    initial begin
        logic [PN-1:0] rq;
        logic [PN*WL-1:0] ln;
        rst           = 1'b1;
        bus.req_in    = '0;
        bus.length_in = '0;
        bus.ready_in  = 1'b0;
        #2;
        checkAllZero("reset");
        repeat (3) @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;

        $display("[TB] single packet, input 0, length 3");
        applyStimulus(4'b0001, packLens(3, 0, 0, 0), 1'b1, 1);
        applyStimulus(4'b0000, packLens(3, 0, 0, 0), 1'b1, 6);

        $display("[TB] round robin over inputs 0,1,3 with length 2");
        applyStimulus(4'b1011, packLens(2, 2, 2, 2), 1'b1, 18);
        applyStimulus(4'b0000, packLens(2, 2, 2, 2), 1'b1, 4);

        $display("[TB] input 2, length 4, ready toggling");
        applyStimulus(4'b0100, packLens(0, 0, 4, 0), 1'b1, 1);
        applyStimulus(4'b0000, packLens(0, 0, 4, 0), 1'b1, 1);
        applyStimulus(4'b0000, packLens(0, 0, 4, 0), 1'b0, 1);
        applyStimulus(4'b0000, packLens(0, 0, 4, 0), 1'b0, 1);
        applyStimulus(4'b0000, packLens(0, 0, 4, 0), 1'b1, 1);
        applyStimulus(4'b0000, packLens(0, 0, 4, 0), 1'b1, 1);
        applyStimulus(4'b0000, packLens(0, 0, 4, 0), 1'b0, 1);
        applyStimulus(4'b0000, packLens(0, 0, 4, 0), 1'b1, 4);

        $display("[TB] zero-length packet on input 1");
        applyStimulus(4'b0010, packLens(0, 0, 0, 0), 1'b1, 1);
        applyStimulus(4'b0000, packLens(0, 0, 0, 0), 1'b1, 3);

        $display("[TB] reset in the middle of a 5-word packet");
        applyStimulus(4'b0001, packLens(5, 0, 0, 0), 1'b1, 3);
        #1 rst = 1'b1;
        #1;
        checkAllZero("midreset");
        @(negedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        applyStimulus(4'b0110, packLens(1, 2, 3, 1), 1'b1, 1);
        applyStimulus(4'b0000, packLens(1, 2, 3, 1), 1'b1, 8);

        $display("[TB] two short packets back to back");
        applyStimulus(4'b0011, packLens(1, 2, 0, 0), 1'b1, 1);
        applyStimulus(4'b0000, packLens(1, 2, 0, 0), 1'b1, 6);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 1500; i++) begin
            rq = ($urandom_range(0, 4) == 0) ? '0 : PN'($urandom_range(0, 15));
            ln = '0;
            for (int j = 0; j < PN; j++) begin
                ln[j*WL +: WL] = WL'($urandom_range(0, 6));
            end
            applyStimulus(rq, ln, ($urandom_range(0, 3) != 0), 1);
        end

        applyStimulus(4'b0000, '0, 1'b1, 30);
        checkOutput("queue_drained", 32'(expQ.size()), 32'(0));
        checkOutput("final_busy", 32'(bus.busy_out), 32'(0));
        $display("[TB] packets completed: %0d", packetsDone);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
